// File: rtl/ti_trigger_fsm_if.sv
// Signal bundle between a host Mealy controller and ti_trigger_fsm.
// The host supplies present/next state; the trigger returns the possibly overridden next state.
interface ti_trigger_fsm_if #(
  parameter int SW  = 5,
  parameter int NCH = 2,
  parameter int CW  = 4
);
  logic              en;
  logic              clr;
  logic [SW-1:0]     pr_state;
  logic [SW-1:0]     nx_in;
  logic [SW-1:0]     nx_out;
  logic              redirect;
  logic [NCH-1:0]    fired;
  logic [NCH*CW-1:0] cnt;
  // Per-channel state (2 bits each): 0 = COUNT, 1 = ARMED, 2 = SPENT
  logic [2*NCH-1:0]  dbg_state;

  modport master (
    output en, clr, pr_state, nx_in,
    input  nx_out, redirect, fired, cnt, dbg_state
  );

  modport slave (
    input  en, clr, pr_state, nx_in,
    output nx_out, redirect, fired, cnt, dbg_state
  );
endinterface

// File: rtl/ti_trigger_fsm.sv
// Next-state override unit: counts departures from watched host states and, past a threshold,
// substitutes a redirect state for the host's computed next state. Flops update on the falling edge.
module ti_trigger_fsm #(
  parameter int                SW     = 5,
  parameter int                NCH    = 2,
  parameter int                CW     = 4,
  parameter int                THRESH = 5,
  parameter logic [NCH*SW-1:0] WATCH  = {5'd3, 5'd3},
  parameter logic [NCH*SW-1:0] REDIR  = {5'd4, 5'd4},
  parameter logic [2*NCH-1:0]  MODE   = '0
) (
  input  logic            clk,
  input  logic            rst,
  ti_trigger_fsm_if.slave bus
);

  typedef enum logic [1:0] {
    ST_COUNT = 2'd0,
    ST_ARMED = 2'd1,
    ST_SPENT = 2'd2
  } ch_state_t;

  localparam logic [CW-1:0] THR   = CW'(THRESH);
  localparam logic [CW:0]   THR_W = (CW+1)'(THRESH);
  localparam logic [CW:0]   ONE_W = (CW+1)'(1);
  localparam logic [CW-1:0] ONE   = CW'(1);

  ch_state_t      state_q [NCH];
  ch_state_t      state_d [NCH];
  logic [CW-1:0]  cnt_q   [NCH];
  logic [CW-1:0]  cnt_d   [NCH];
  logic [NCH-1:0] fired_q;
  logic [NCH-1:0] fired_d;
  logic [NCH-1:0] visit;
  logic [NCH-1:0] hit;
  logic [1:0]     mode;

  // A visit is a departure from the watched state; self-loops never qualify.
  always_comb begin
    visit = '0;
    hit   = '0;
    for (int i = 0; i < NCH; i++) begin
      visit[i] = bus.en
                 && (bus.pr_state == WATCH[i*SW +: SW])
                 && (bus.nx_in    != WATCH[i*SW +: SW]);
      hit[i]   = visit[i]
                 && (((state_q[i] == ST_COUNT) && (({1'b0, cnt_q[i]} + ONE_W) >= THR_W))
                     || (state_q[i] == ST_ARMED));
    end
  end

  // Walk from the top index down so the lowest-index hitting channel wins.
  always_comb begin
    bus.nx_out   = bus.nx_in;
    bus.redirect = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (hit[i]) begin
        bus.nx_out   = REDIR[i*SW +: SW];
        bus.redirect = 1'b1;
      end
    end
  end

  always_comb begin
    mode    = 2'd0;
    fired_d = fired_q;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      mode       = MODE[2*i +: 2];
      if (bus.clr) begin
        state_d[i] = ST_COUNT;
        cnt_d[i]   = '0;
        fired_d[i] = 1'b0;
      end else begin
        // Periodic fire status is a one-cycle pulse, dropped at any edge without a new hit.
        if ((mode == 2'd1) && !hit[i]) begin
          fired_d[i] = 1'b0;
        end
        if ((state_q[i] == ST_COUNT) && visit[i]) begin
          if (!hit[i]) begin
            cnt_d[i] = cnt_q[i] + ONE;
          end else begin
            fired_d[i] = 1'b1;
            case (mode)
              2'd1: begin
                cnt_d[i] = '0;
              end
              2'd2: begin
                state_d[i] = ST_SPENT;
                cnt_d[i]   = THR;
              end
              default: begin
                state_d[i] = ST_ARMED;
                cnt_d[i]   = THR;
              end
            endcase
          end
        end
      end
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= ST_COUNT;
        cnt_q[i]   <= '0;
      end
      fired_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      fired_q <= fired_d;
    end
  end

  always_comb begin
    bus.fired     = fired_q;
    bus.cnt       = '0;
    bus.dbg_state = '0;
    for (int i = 0; i < NCH; i++) begin
      bus.cnt[i*CW +: CW]     = cnt_q[i];
      bus.dbg_state[2*i +: 2] = state_q[i];
    end
  end

endmodule

// File: doc/ti_trigger_fsm.md
# ti_trigger_fsm

Parametrised next-state override unit that sits between a host Mealy controller's next-state logic and its state register. It counts departures from up to NCH watched states and, once a per-channel threshold is reached, substitutes a programmed redirect state for the host's computed next state. Each channel has an independent firing mode: sticky, periodic or single-shot. The block generalises the fixed single-state, fixed-threshold counter trigger used in the suite's controller benchmarks.

## Interface

- SW, 5: host state encoding width.
- NCH, 2: number of independent watch channels.
- CW, 4: per-channel counter width.
- THRESH, 5: visit count at which a channel fires. Legal range is 1..2^CW-1.
- WATCH, {5'd3, 5'd3}: flat NCH*SW vector. Channel i watches WATCH[i*SW +: SW].
- REDIR, {5'd4, 5'd4}: flat NCH*SW vector. Channel i's redirect target is REDIR[i*SW +: SW].
- MODE, 0: flat 2*NCH vector, MODE[2i +: 2] per channel. 0 = sticky, 1 = periodic, 2 = single-shot, 3 = reserved (behaves as 0).

Ports:

- clk  in  1  clock. All flops update on the falling edge, matching the host controllers.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  global enable for counting and redirect.
- clr  in  1  synchronous clear of all channels.
- pr_state  in  SW  host present state.
- nx_in  in  SW  host-computed next state.
- nx_out  out  SW  next state delivered to the host state register.
- redirect  out  1  combinational; high when nx_out is overridden this cycle.
- fired  out  NCH  registered per-channel fire status.
- cnt  out  NCH*CW  registered per-channel counters.

## Operation

- Channel state machine, 2 bits per channel: COUNT, ARMED, SPENT. Reset and clr force every channel to COUNT.
- A visit qualifies for channel i when en=1, pr_state==WATCH_i and nx_in!=WATCH_i. Self-loops are not visits.
- A channel hits when it has a qualifying visit and either:
  - it is in COUNT and cnt_i+1 >= THRESH, or
  - it is in ARMED.
- Redirect: if any channel hits, nx_out = REDIR of the lowest-index hitting channel and redirect=1. Otherwise nx_out=nx_in and redirect=0.
- Counter update at the falling edge, one increment per qualifying visit per channel. All matching channels count, regardless of redirect priority.
- COUNT, no hit: cnt_i += 1.
- COUNT, hit, by mode:
  - Mode 0: go to ARMED, cnt_i = THRESH, fired_i = 1 (sticky).
  - Mode 1: stay in COUNT, cnt_i = 0, fired_i = 1 for exactly one cycle.
  - Mode 2: go to SPENT, cnt_i = THRESH, fired_i = 1 (sticky).
- ARMED: every qualifying visit is redirected; cnt_i holds at THRESH.
- SPENT: no counting, no redirect; cnt_i holds at THRESH.
- In mode 1, fired_i returns to 0 at the next falling edge unless another hit occurs.
- en=0: no counting, no redirect, nx_out=nx_in. Registered state holds.
- clr=1 at an edge: all channels go to COUNT with cnt=0 and fired=0. A coincident qualifying visit is not counted. clr does not mask the combinational redirect in the current cycle.
- Arithmetic: unsigned CW bits. Counters never wrap, because THRESH < 2^CW and each counter saturates or resets at THRESH.

## Timing

- nx_out and redirect: zero latency, combinational from pr_state, nx_in, en and registered channel state.
- cnt and fired: update at the falling edge that latches the qualifying visit into the host.
- Reset values while rst=0, asserted asynchronously:
  - every channel state = COUNT
  - cnt = 0
  - fired = 0
  - nx_out = nx_in
  - redirect = 0
- Reset mid-count discards all progress immediately; recovery starts at the first falling edge after rst rises.
- THRESH=1: the first qualifying visit is redirected.

## Test plan

- Reset: hold rst=0 with nx_in=10 -> nx_out=10, redirect=0, fired=0, cnt=0. Deassert rst -> outputs unchanged.
- Sticky, defaults (channel 0, WATCH=3, REDIR=4, THRESH=5):
  - 4 departures 3->10 -> nx_out=10 and cnt0 reaches 4.
  - 5th departure -> nx_out=4 and redirect=1; after the edge fired[0]=1 and cnt0=5.
  - 6th departure -> nx_out=4 again.
- Self-loop and enable: pr_state=3, nx_in=3 for 3 edges -> cnt0 unchanged. en=0 with pr_state=3, nx_in=10 -> no count, nx_out=10.
- Periodic (MODE0=1): 10 departures -> visits 5 and 10 redirected to 4, visits 6-9 pass 10. fired[0] pulses one cycle after edges 5 and 10; cnt0 returns to 0 after each.
- Single-shot (MODE0=2): 8 departures -> only visit 5 is redirected. fired[0] stays 1 and cnt0 stays at 5.
- Priority and clear:
  - Set WATCH1=3, REDIR1=7, and THRESH=1 -> both channels hit and nx_out=4 (channel 0 wins); both cnt=1 after the edge.
  - With cnt0=3, assert clr together with a qualifying visit -> cnt0=0 after the edge.
  - With cnt0=3, pulse rst=0 mid-cycle -> cnt0=0 immediately.
